// File: rtl/avg_pool_unit.sv
// -----------------------------------------------------------------------------
// avg_pool_unit
// Streaming 2x2 average-pool arithmetic engine for the CNN core's pool_layer.
// Accumulates 2**WINDOW_LOG2 signed samples, one per enabled clock, then
// registers their mean on the edge that accepts the last sample of the window.
//
// Parameters
//   DATA_W       width of the signed input sample and of the signed average
//   WINDOW_LOG2  log2 of the number of samples per window (2 -> 2x2 pool)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; it wins over enable
//   enable     in   sample valid; layer2 is accepted on each edge with enable=1
//   layer2     in   signed input sample (two's complement), DATA_W bits
//   avg        out  registered signed window average, held between windows
//   avg_valid  out  one-cycle pulse on the edge where avg takes a new value
//
// Configuration macro
//   AVG_POOL_ROUND_EN  when defined, the average is rounded half toward +inf
//                      and clamped to the DATA_W signed range; when undefined
//                      it is the plain floor of the arithmetic shift.
// -----------------------------------------------------------------------------
module avg_pool_unit #(
   parameter int DATA_W      = 32,
   parameter int WINDOW_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DATA_W-1:0] layer2,
   output logic [DATA_W-1:0] avg,
   output logic              avg_valid
);

   // WINDOW_LOG2 guard bits make the accumulator wide enough for the sum of a
   // full window of extreme samples.
   localparam int ACC_W = DATA_W + WINDOW_LOG2;
   localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;

   logic signed [ACC_W-1:0]  acc_reg;
   logic [WINDOW_LOG2-1:0]   cnt_reg;
   logic [DATA_W-1:0]        avg_reg;
   logic                     avg_valid_reg;

   logic signed [ACC_W-1:0]  sample_ext;
   logic signed [ACC_W-1:0]  sum_next;
   logic [DATA_W-1:0]        avg_next;

   assign sample_ext = {{WINDOW_LOG2{layer2[DATA_W-1]}}, layer2};
   assign sum_next   = acc_reg + sample_ext;

`ifdef AVG_POOL_ROUND_EN
   // One extra bit so adding the half-LSB cannot wrap the full-window sum.
   localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (WINDOW_LOG2 - 1);
   localparam logic signed [ACC_W:0] AVG_MAX  = (ACC_W+1)'({1'b0, {(DATA_W-1){1'b1}}});
   localparam logic signed [ACC_W:0] AVG_MIN  = ~AVG_MAX;

   logic signed [ACC_W:0] rnd_sum;
   logic signed [ACC_W:0] rnd_shift;

   always_comb begin
      rnd_sum   = {sum_next[ACC_W-1], sum_next} + RND_HALF;
      rnd_shift = rnd_sum >>> WINDOW_LOG2;
      avg_next  = DATA_W'(rnd_shift);
      if (rnd_shift > AVG_MAX) begin
         avg_next = DATA_W'(AVG_MAX);
      end else if (rnd_shift < AVG_MIN) begin
         avg_next = DATA_W'(AVG_MIN);
      end
   end
`else
   // Floor division: the arithmetic shift of a window sum always fits DATA_W.
   always_comb begin
      avg_next = DATA_W'(sum_next >>> WINDOW_LOG2);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg       <= '0;
         cnt_reg       <= '0;
         avg_reg       <= '0;
         avg_valid_reg <= 1'b0;
      end else begin
         avg_valid_reg <= 1'b0;
         if (enable) begin
            if (cnt_reg == CNT_LAST) begin
               // Last sample of the window: publish the mean and restart so the
               // next window can begin on the very next edge.
               avg_reg       <= avg_next;
               avg_valid_reg <= 1'b1;
               acc_reg       <= '0;
               cnt_reg       <= '0;
            end else begin
               acc_reg <= sum_next;
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   end

   assign avg       = avg_reg;
   assign avg_valid = avg_valid_reg;

endmodule

// File: tb/tb_avg_pool_unit.sv
// -----------------------------------------------------------------------------
// tb_avg_pool_unit
// Directed bench for avg_pool_unit (DATA_W=32, WINDOW_LOG2=2). Inputs are
// driven on the falling edge, outputs are sampled 1 time unit after the rising
// edge. Expected values are hand-computed; rounded variants are selected with
// AVG_POOL_ROUND_EN to match the build of the design.
// -----------------------------------------------------------------------------
module tb_avg_pool_unit;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [31:0] layer2;
   logic [31:0] avg;
   logic        avg_valid;

   int tests_run;
   int tests_failed;

   avg_pool_unit #(
      .DATA_W      (32),
      .WINDOW_LOG2 (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .layer2    (layer2),
      .avg       (avg),
      .avg_valid (avg_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef AVG_POOL_ROUND_EN
   localparam logic [31:0] EXP_NEG  = 32'hFFFF_FFFE; // -2
   localparam logic [31:0] EXP_ONES = 32'd2;
   localparam logic [31:0] EXP_B2B1 = 32'd3;
   localparam logic [31:0] EXP_B2B2 = 32'd7;
`else
   localparam logic [31:0] EXP_NEG  = 32'hFFFF_FFFD; // -3
   localparam logic [31:0] EXP_ONES = 32'd1;
   localparam logic [31:0] EXP_B2B1 = 32'd2;
   localparam logic [31:0] EXP_B2B2 = 32'd6;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", tag, got);
      end
   endtask

   // One clock: drive on the falling edge, return just after the rising edge.
   task automatic step(input logic r, input logic en, input logic [31:0] d);
      @(negedge clk);
      rst    = r;
      enable = en;
      layer2 = d;
      @(posedge clk);
      #1;
   endtask

   // Feed one full window and check the non-final edges show no valid pulse.
   task automatic window(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input logic [31:0] exp);
      step(1'b0, 1'b1, a);
      step(1'b0, 1'b1, b);
      step(1'b0, 1'b1, c);
      check({tag, "_mid_valid"}, {31'd0, avg_valid}, 32'd0);
      step(1'b0, 1'b1, d);
      check({tag, "_avg"}, avg, exp);
      check({tag, "_valid"}, {31'd0, avg_valid}, 32'd1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst    = 1'b1;
      enable = 1'b0;
      layer2 = '0;

      step(1'b1, 1'b1, 32'd55);
      check("reset_avg", avg, 32'd0);
      check("reset_valid", {31'd0, avg_valid}, 32'd0);

      window("basic", 32'd10, 32'd20, 32'd30, 32'd40, 32'd25);
      step(1'b0, 1'b0, 32'd0);
      check("basic_hold_avg", avg, 32'd25);
      check("basic_pulse_end", {31'd0, avg_valid}, 32'd0);

      window("neg", -32'sd1, -32'sd2, -32'sd3, -32'sd4, EXP_NEG);
      window("ones", 32'd1, 32'd1, 32'd1, 32'd3, EXP_ONES);
      window("max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      window("min", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);

      // Gaps in enable do not break the window.
      step(1'b0, 1'b1, 32'd4);
      step(1'b0, 1'b1, 32'd8);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'd999);
         check($sformatf("gap%0d_avg", i), avg, 32'h8000_0000);
         check($sformatf("gap%0d_valid", i), {31'd0, avg_valid}, 32'd0);
      end
      step(1'b0, 1'b1, 32'd12);
      check("gap_pre_valid", {31'd0, avg_valid}, 32'd0);
      step(1'b0, 1'b1, 32'd16);
      check("gap_avg", avg, 32'd10);
      check("gap_valid", {31'd0, avg_valid}, 32'd1);

      // Reset mid-window drops the partial sum and the sample presented with it.
      step(1'b0, 1'b1, 32'd100);
      step(1'b0, 1'b1, 32'd100);
      step(1'b1, 1'b1, 32'd100);
      check("midrst_avg", avg, 32'd0);
      check("midrst_valid", {31'd0, avg_valid}, 32'd0);
      window("after_rst", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

      // Back-to-back windows 1..8.
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 32'(i));
         if (i == 4) begin
            check("b2b_w1_avg", avg, EXP_B2B1);
            check("b2b_w1_valid", {31'd0, avg_valid}, 32'd1);
         end else if (i == 5) begin
            check("b2b_w2_start_valid", {31'd0, avg_valid}, 32'd0);
         end else if (i == 8) begin
            check("b2b_w2_avg", avg, EXP_B2B2);
            check("b2b_w2_valid", {31'd0, avg_valid}, 32'd1);
         end
      end
      step(1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 32'd0);
      check("b2b_hold_avg", avg, EXP_B2B2);
      check("b2b_hold_valid", {31'd0, avg_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
